// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch queue.
package fetch_pkg;

  // Entry field widths; the top-level DataWidth/Address must match these.
  localparam int unsigned FETCH_DATA_W = 32;
  localparam int unsigned FETCH_ADDR_W = 8;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam int unsigned PC_STEP   = 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH
  } fetch_state_e;

  typedef struct packed {
    logic [FETCH_DATA_W-1:0] instr;
    logic [FETCH_ADDR_W-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch queue: synchronous FIFO of fetch entries with clear, count and flags.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned Depth = 4,
  parameter int unsigned CntW  = $clog2(Depth) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear,
  input  logic            push,
  input  fetch_entry_t    push_data,
  input  logic            pop,
  output fetch_entry_t    head,
  output logic [CntW-1:0] count,
  output logic            full,
  output logic            empty
);

  localparam int unsigned PtrW = $clog2(Depth);

  fetch_entry_t    mem_q [Depth];
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            push_ok, pop_ok;

  // Pointer and occupancy bookkeeping; clear wins over push/pop.
  always_comb begin
    push_ok  = push && !full;
    pop_ok   = pop && !empty;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (clear) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      // Depth is a power of two, so pointers wrap naturally.
      if (push_ok) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      count_d = count_q + CntW'(push_ok) - CntW'(pop_ok);
    end
  end

  // Pointer/count registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are only observed while the queue is non-empty.
  always_ff @(posedge clk) begin
    if (push_ok && !clear) mem_q[wr_ptr_q] <= push_data;
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;
  assign empty = (count_q == '0);
  assign full  = (count_q == CntW'(Depth));

endmodule

// File: rtl/instr_fetch_queue.sv
// Fetch stage: PC generation, in-order imem requests, prefetch queue and
// redirect flush. Optional macro FETCH_BYPASS_EN forwards a response straight
// to decode when the queue is empty (0-cycle latency).
module instr_fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned        DataWidth = FETCH_DATA_W,
  parameter int unsigned        Address   = FETCH_ADDR_W,
  parameter int unsigned        Depth     = 4,
  parameter logic [Address-1:0] ResetPc   = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 fetch_en,
  input  logic                 redirect_valid,
  input  logic [Address-1:0]   redirect_pc,
  output logic                 imem_req_valid,
  input  logic                 imem_req_ready,
  output logic [Address-1:0]   imem_req_addr,
  input  logic                 imem_rsp_valid,
  input  logic [DataWidth-1:0] imem_rsp_data,
  output logic                 instr_valid,
  input  logic                 instr_ready,
  output logic [DataWidth-1:0] instruction,
  output logic [Address-1:0]   instr_pc,
  output logic                 busy
);

  localparam int unsigned        CntW   = $clog2(Depth) + 1;
  localparam logic [Address-1:0] PcStep = Address'(PC_STEP);

  fetch_state_e     state_q, state_d;
  logic [Address-1:0] pc_q, pc_d;
  logic [Address-1:0] rsp_pc_q, rsp_pc_d;
  logic [Address-1:0] redirect_tgt;
  logic [CntW-1:0]  outstanding_q, outstanding_d;
  logic [CntW-1:0]  drop_cnt_q, drop_cnt_d;
  logic [CntW-1:0]  fifo_count;
  logic             fifo_full, fifo_empty, fifo_push, fifo_pop;
  fetch_entry_t     push_entry, head_entry;
  logic             credit_ok, req_fire, rsp_drop, rsp_keep, bypass;

  fetch_fifo #(
    .Depth (Depth),
    .CntW  (CntW)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .clear     (redirect_valid),
    .push      (fifo_push),
    .push_data (push_entry),
    .pop       (fifo_pop),
    .head      (head_entry),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Request credit, response classification and decode-side handshake.
  always_comb begin
    // Queue slots plus in-flight words never exceed Depth, so responses always fit.
    credit_ok      = ({1'b0, fifo_count} + {1'b0, outstanding_q}) < (CntW + 1)'(Depth);
    imem_req_valid = (state_q == RUN) && fetch_en && !redirect_valid && credit_ok && !fifo_full;
    req_fire       = imem_req_valid && imem_req_ready;
    // A response arriving alongside a redirect belongs to the old path.
    rsp_drop       = imem_rsp_valid && ((drop_cnt_q != '0) || redirect_valid);
    rsp_keep       = imem_rsp_valid && !rsp_drop;
`ifdef FETCH_BYPASS_EN
    bypass         = rsp_keep && fifo_empty;
`else
    bypass         = 1'b0;
`endif
    instr_valid = !fifo_empty || bypass;
    instruction = '0;
    instr_pc    = '0;
    if (!fifo_empty) begin
      instruction = head_entry.instr;
      instr_pc    = head_entry.pc;
    end else if (bypass) begin
      instruction = imem_rsp_data;
      instr_pc    = rsp_pc_q;
    end
    fifo_pop         = !fifo_empty && instr_ready && !redirect_valid;
    fifo_push        = rsp_keep && !(bypass && instr_ready);
    push_entry.instr = imem_rsp_data;
    push_entry.pc    = rsp_pc_q;
  end

  // PC, response-PC and in-flight counter updates; redirect has top priority.
  always_comb begin
    redirect_tgt  = redirect_pc & ~Address'(3);
    pc_d          = pc_q;
    rsp_pc_d      = rsp_pc_q;
    outstanding_d = outstanding_q + CntW'(req_fire) - CntW'(imem_rsp_valid);
    drop_cnt_d    = drop_cnt_q;
    if (redirect_valid) begin
      pc_d       = redirect_tgt;
      rsp_pc_d   = redirect_tgt;
      // Every word still in flight is stale; in FLUSH this equals the old drop count.
      drop_cnt_d = outstanding_q - CntW'(imem_rsp_valid);
    end else begin
      if (req_fire) pc_d = pc_q + PcStep;
      if (rsp_keep) rsp_pc_d = rsp_pc_q + PcStep;
      if (rsp_drop) drop_cnt_d = drop_cnt_q - CntW'(1);
    end
  end

  // Fetch FSM next state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (fetch_en) state_d = RUN;
      RUN:     if (!fetch_en && outstanding_q == '0) state_d = IDLE;
      FLUSH:   if (drop_cnt_d == '0) state_d = fetch_en ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
    if (redirect_valid && drop_cnt_d != '0) state_d = FLUSH;
  end

  // State registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      pc_q          <= ResetPc;
      rsp_pc_q      <= ResetPc;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      rsp_pc_q      <= rsp_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  assign imem_req_addr = pc_q;
  assign busy          = (state_q != IDLE);

endmodule
